// File: rtl/spi_lcd_receiver_pkg.sv
// Shared opcodes, command FSM encoding and window check used by the SPI LCD receiver.
package spi_lcd_receiver_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CASET  = 3'd1,
    ST_PASET  = 3'd2,
    ST_RAMWR  = 3'd3,
    ST_IGNORE = 3'd4
  } cmd_state_e;

  // A window edge pair is usable only if it is ordered and fits the panel.
  function automatic logic window_ok(input logic [15:0] start,
                                     input logic [15:0] stop,
                                     input logic [15:0] limit);
    return (start <= stop) && (stop < limit);
  endfunction

endpackage

// File: rtl/spi_lcd_receiver_if.sv
// SPI pins in, byte/pixel strobes out, plus the command FSM state for observation.
interface spi_lcd_receiver_if #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
);
  import spi_lcd_receiver_pkg::*;

  logic          i_sclk;
  logic          i_mosi;
  logic          i_dc;
  logic          i_cs;
  logic          o_byte_valid;
  logic [7:0]    o_byte;
  logic          o_byte_dc;
  logic          o_pix_valid;
  logic [XW-1:0] o_pix_x;
  logic [YW-1:0] o_pix_y;
  logic [15:0]   o_pix_color;
  logic          o_frame_done;
  logic          o_err;
  cmd_state_e    dbg_state;

  // Every *_valid / *_done output is a single-cycle strobe with no ready:
  // the consumer must take it that cycle. Payloads hold their last value
  // between strobes.
  modport master (
    output i_sclk, i_mosi, i_dc, i_cs,
    input  o_byte_valid, o_byte, o_byte_dc, o_pix_valid, o_pix_x, o_pix_y,
           o_pix_color, o_frame_done, o_err, dbg_state
  );

  modport slave (
    input  i_sclk, i_mosi, i_dc, i_cs,
    output o_byte_valid, o_byte, o_byte_dc, o_pix_valid, o_pix_x, o_pix_y,
           o_pix_color, o_frame_done, o_err, dbg_state
  );
endinterface

// File: rtl/spi_lcd_receiver_byte_deserializer.sv
// Synchronizes the asynchronous SPI pins and turns MSB-first bits into byte strobes.
module spi_byte_deserializer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       dc,
  input  logic       cs,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       err
);

  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [1:0] dc_sync;
  logic [1:0] cs_sync;
  logic       sclk_prev;
  logic       sclk_rise;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       dc_lat;
  logic       pend;

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sclk_sync  <= 2'b00;
      mosi_sync  <= 2'b00;
      dc_sync    <= 2'b00;
      cs_sync    <= 2'b11;
      sclk_prev  <= 1'b0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      dc_lat     <= 1'b0;
      pend       <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_dc    <= 1'b0;
      err        <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[0], sclk};
      mosi_sync  <= {mosi_sync[0], mosi};
      dc_sync    <= {dc_sync[0], dc};
      cs_sync    <= {cs_sync[0], cs};
      sclk_prev  <= sclk_sync[1];
      byte_valid <= pend;
      pend       <= 1'b0;
      // shreg is quiet for several cycles after the 8th bit, so it is read a cycle late.
      if (pend) begin
        byte_data <= shreg;
        byte_dc   <= dc_lat;
      end
      if (cs_sync[1]) begin
        bit_cnt <= 3'd0;
        if (bit_cnt != 3'd0) err <= 1'b1;
      end else if (sclk_rise) begin
        shreg   <= {shreg[6:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          dc_lat <= dc_sync[1];
          pend   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_lcd_receiver.sv
// Display-side SPI responder: decodes CASET/PASET/RAMWR into per-pixel write strobes.
module spi_lcd_receiver
  import spi_lcd_receiver_pkg::*;
#(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  spi_lcd_receiver_if.slave  bus
);

  localparam logic [15:0] W16 = 16'(WIDTH);
  localparam logic [15:0] H16 = 16'(HEIGHT);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_dc;
  logic          des_err;

  cmd_state_e    state;
  cmd_state_e    state_next;
  logic [1:0]    pidx;
  logic [7:0]    p_sh;
  logic [7:0]    p_sl;
  logic [7:0]    p_eh;
  logic [15:0]   p_start;
  logic [15:0]   p_end;
  logic [XW-1:0] xs;
  logic [XW-1:0] xe;
  logic [YW-1:0] ys;
  logic [YW-1:0] ye;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          hi_valid;
  logic [7:0]    hi_byte;
  logic          win_err;
  logic          pix_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [15:0]   pix_color;
  logic          frame_done;

  spi_byte_deserializer u_des (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .sclk       (bus.i_sclk),
    .mosi       (bus.i_mosi),
    .dc         (bus.i_dc),
    .cs         (bus.i_cs),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .err        (des_err)
  );

  assign p_start = {p_sh, p_sl};
  assign p_end   = {p_eh, byte_data};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  // A command byte always redirects the FSM; window loads end after their 4th data byte.
  always_comb begin
    state_next = state;
    if (byte_valid) begin
      if (!byte_dc) begin
        case (byte_data)
          CMD_CASET: state_next = ST_CASET;
          CMD_PASET: state_next = ST_PASET;
          CMD_RAMWR: state_next = ST_RAMWR;
          default:   state_next = ST_IGNORE;
        endcase
      end else if ((state == ST_CASET || state == ST_PASET) && pidx == 2'd3) begin
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pidx       <= 2'd0;
      p_sh       <= 8'h00;
      p_sl       <= 8'h00;
      p_eh       <= 8'h00;
      xs         <= '0;
      xe         <= XW'(WIDTH - 1);
      ys         <= '0;
      ye         <= YW'(HEIGHT - 1);
      cx         <= '0;
      cy         <= '0;
      hi_valid   <= 1'b0;
      hi_byte    <= 8'h00;
      win_err    <= 1'b0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_color  <= 16'h0000;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (byte_valid) begin
        if (!byte_dc) begin
          // Any command drops a half-received pixel without flagging an error.
          pidx     <= 2'd0;
          hi_valid <= 1'b0;
          if (byte_data == CMD_RAMWR) begin
            cx <= xs;
            cy <= ys;
          end
        end else begin
          case (state)
            ST_CASET, ST_PASET: begin
              pidx <= pidx + 2'd1;
              case (pidx)
                2'd0: p_sh <= byte_data;
                2'd1: p_sl <= byte_data;
                2'd2: p_eh <= byte_data;
                default: begin
                  if (state == ST_CASET) begin
                    if (window_ok(p_start, p_end, W16)) begin
                      xs <= XW'(p_start);
                      xe <= XW'(p_end);
                    end else begin
                      win_err <= 1'b1;
                    end
                  end else begin
                    if (window_ok(p_start, p_end, H16)) begin
                      ys <= YW'(p_start);
                      ye <= YW'(p_end);
                    end else begin
                      win_err <= 1'b1;
                    end
                  end
                end
              endcase
            end
            ST_RAMWR: begin
              if (!hi_valid) begin
                hi_byte  <= byte_data;
                hi_valid <= 1'b1;
              end else begin
                hi_valid  <= 1'b0;
                pix_valid <= 1'b1;
                pix_x     <= cx;
                pix_y     <= cy;
                pix_color <= {hi_byte, byte_data};
                if (cx < xe) begin
                  cx <= cx + XW'(1);
                end else begin
                  cx <= xs;
                  if (cy < ye) begin
                    cy <= cy + YW'(1);
                  end else begin
                    cy         <= ys;
                    frame_done <= 1'b1;
                  end
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.o_byte_valid = byte_valid;
  assign bus.o_byte       = byte_data;
  assign bus.o_byte_dc    = byte_dc;
  assign bus.o_pix_valid  = pix_valid;
  assign bus.o_pix_x      = pix_x;
  assign bus.o_pix_y      = pix_y;
  assign bus.o_pix_color  = pix_color;
  assign bus.o_frame_done = frame_done;
  assign bus.o_err        = des_err | win_err;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_spi_lcd_receiver.sv
// Randomized bench for spi_lcd_receiver against a window/raster model of the panel.
module tb_spi_lcd_receiver;
  import spi_lcd_receiver_pkg::*;

  localparam int WIDTH  = 24;
  localparam int HEIGHT = 32;
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);
  localparam int PW     = 1 + XW + YW + 16;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  spi_lcd_receiver_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

  spi_lcd_receiver #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0]    exp_b_q[$];
  int            rise_q[$];
  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_bytes  = 0;
  int n_pix    = 0;
  int n_push_b = 0;
  int n_push_p = 0;

  // panel model
  int m_xs, m_xe, m_ys, m_ye, ram_k;
  bit ram_active, exp_err, rand_timing;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_xs = 0; m_xe = WIDTH - 1; m_ys = 0; m_ye = HEIGHT - 1;
    ram_k = 0; ram_active = 0; exp_err = 0;
  endtask

  // Pixel k of a RAMWR burst walks the window in raster order and wraps.
  function automatic logic [PW-1:0] exp_pix(input int k, input logic [15:0] c);
    int w, h, n;
    w = m_xe - m_xs + 1;
    h = m_ye - m_ys + 1;
    n = k % (w * h);
    return {(n == w * h - 1), XW'(m_xs + n % w), YW'(m_ys + n / w), c};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge i_clk) begin
    if (bus.o_byte_valid) begin
      n_bytes++;
      if (exp_b_q.size() == 0) check("byte_extra", n_bytes, n_push_b);
      else begin
        check("byte", {bus.o_byte_dc, bus.o_byte}, exp_b_q.pop_front());
        check("byte_lat", cyc - rise_q.pop_front(), 4);
      end
    end
    if (bus.o_pix_valid) begin
      n_pix++;
      if (exp_q.size() == 0) check("pix_extra", n_pix, n_push_p);
      else check("pix", {bus.o_frame_done, bus.o_pix_x, bus.o_pix_y, bus.o_pix_color},
                 exp_q.pop_front());
    end else if (bus.o_frame_done) begin
      check("frame_done_alone", bus.o_pix_valid, 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc, input bit push);
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.i_mosi = b[i];
      bus.i_dc   = dc;
      repeat (rand_timing ? $urandom_range(2, 3) : 2) @(negedge i_clk);
      bus.i_sclk = 1'b1;
      if (i == 0 && push) begin
        exp_b_q.push_back({dc, b});
        rise_q.push_back(cyc);
        n_push_b++;
      end
      repeat (rand_timing ? $urandom_range(2, 3) : 2) @(negedge i_clk);
      bus.i_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc, 1'b1);
  endtask

  task automatic cs_pulse();
    bus.i_cs = 1'b1;
    repeat (4) @(negedge i_clk);
    bus.i_cs = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    send_byte(b, 1'b0);
    ram_active = (b == CMD_RAMWR);
    ram_k = 0;
  endtask

  task automatic set_window(input bit is_col, input int s, input int e);
    int limit;
    cmd(is_col ? CMD_CASET : CMD_PASET);
    send_byte(s[15:8], 1'b1);
    send_byte(s[7:0], 1'b1);
    send_byte(e[15:8], 1'b1);
    send_byte(e[7:0], 1'b1);
    limit = is_col ? WIDTH : HEIGHT;
    if (s <= e && e < limit) begin
      if (is_col) begin m_xs = s; m_xe = e; end
      else        begin m_ys = s; m_ye = e; end
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic pixel(input logic [15:0] c, input bit split_cs);
    send_byte(c[15:8], 1'b1);
    if (split_cs) cs_pulse();
    if (ram_active) begin
      exp_q.push_back(exp_pix(ram_k, c));
      ram_k++;
      n_push_p++;
    end
    send_byte(c[7:0], 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bv"},    bus.o_byte_valid, 0);
    check({tag, "_byte"},  bus.o_byte, 0);
    check({tag, "_dc"},    bus.o_byte_dc, 0);
    check({tag, "_pv"},    bus.o_pix_valid, 0);
    check({tag, "_x"},     bus.o_pix_x, 0);
    check({tag, "_y"},     bus.o_pix_y, 0);
    check({tag, "_color"}, bus.o_pix_color, 0);
    check({tag, "_fd"},    bus.o_frame_done, 0);
    check({tag, "_err"},   bus.o_err, 0);
    check({tag, "_state"}, bus.dbg_state, ST_IDLE);
  endtask

  task automatic do_reset(input string tag);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge i_clk);
    i_rst = 1'b1;
    model_reset();
    repeat (3) @(negedge i_clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb, np, mode, s, e, saved;
    logic [15:0] c;
    bus.i_sclk = 1'b0; bus.i_mosi = 1'b0; bus.i_dc = 1'b0; bus.i_cs = 1'b1;
    rand_timing = 1'b0;
    model_reset();
    repeat (3) @(negedge i_clk);
    check_reset_outputs("rst");
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);

    // single byte
    bus.i_cs = 1'b0;
    repeat (3) @(negedge i_clk);
    send_byte(8'hA5, 1'b1);
    repeat (6) @(negedge i_clk);
    check("single_cnt", n_bytes, 1);
    check("single_byte", bus.o_byte, 8'hA5);
    check("single_dc", bus.o_byte_dc, 1);
    check("single_err", bus.o_err, 0);

    // full default frame plus one wrapped pixel
    cmd(CMD_RAMWR);
    repeat (6) @(negedge i_clk);
    check("ramwr_state", bus.dbg_state, ST_RAMWR);
    for (int i = 0; i < WIDTH * HEIGHT + 1; i++) pixel(16'h0000, 1'b0);
    repeat (8) @(negedge i_clk);
    check("frame_pix_cnt", n_pix, WIDTH * HEIGHT + 1);

    // small window
    set_window(1'b1, 2, 3);
    set_window(1'b0, 5, 5);
    cmd(CMD_RAMWR);
    pixel(16'hF800, 1'b0);
    pixel(16'h07E0, 1'b0);
    c = 16'($urandom);
    pixel(c, 1'b0);
    repeat (8) @(negedge i_clk);
    check("win_hold_x", bus.o_pix_x, 2);
    check("win_hold_color", bus.o_pix_color, c);
    check("win_err", bus.o_err, 0);

    // CS abort after 5 bits
    nb = n_bytes;
    send_bits(8'hE7, 5, 1'b1, 1'b0);
    bus.i_cs = 1'b1;
    repeat (6) @(negedge i_clk);
    check("abort_err", bus.o_err, 1);
    check("abort_no_byte", n_bytes, nb);
    bus.i_cs = 1'b0;
    repeat (3) @(negedge i_clk);
    send_byte(8'h3C, 1'b1);
    repeat (8) @(negedge i_clk);
    check("abort_err_sticky", bus.o_err, 1);
    check("abort_next_byte", n_bytes, nb + 1);

    // invalid window leaves default window in place
    do_reset("rst2");
    set_window(1'b1, 10, 4);
    cmd(CMD_RAMWR);
    pixel(16'($urandom), 1'b0);
    repeat (8) @(negedge i_clk);
    check("inv_err", bus.o_err, 1);

    // randomized windows and bursts
    do_reset("rst3");
    rand_timing = 1'b1;
    for (int it = 0; it < 6; it++) begin
      s = $urandom_range(0, WIDTH - 1);
      e = $urandom_range(0, WIDTH + 2);
      set_window(1'b1, s, e);
      s = $urandom_range(0, HEIGHT - 1);
      e = $urandom_range(0, HEIGHT + 2);
      set_window(1'b0, s, e);
      if ($urandom_range(0, 2) == 0) begin
        cmd(8'h11);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
      end
      cmd(CMD_RAMWR);
      np = $urandom_range(1, 16);
      for (int p = 0; p < np; p++) begin
        c = 16'($urandom);
        mode = $urandom_range(0, 7);
        if (mode == 0) pixel(c, 1'b1);
        else if (mode == 1) begin
          send_byte(c[15:8], 1'b1);
          cmd(8'h00);
          send_byte(c[7:0], 1'b1);
          break;
        end else pixel(c, 1'b0);
      end
      repeat (10) @(negedge i_clk);
      check("rand_err", bus.o_err, exp_err);
    end

    // async reset between HI and LO of a pixel
    rand_timing = 1'b0;
    cmd(CMD_RAMWR);
    c = 16'($urandom) | 16'h8000;
    send_byte(c[15:8], 1'b1);
    repeat (5) @(negedge i_clk);
    do_reset("rst_mid");
    saved = n_pix;
    send_byte(c[7:0], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    repeat (8) @(negedge i_clk);
    check("mid_no_pix", n_pix, saved);
    check("mid_state", bus.dbg_state, ST_IDLE);

    repeat (20) @(negedge i_clk);
    check("byte_q_drain", exp_b_q.size(), 0);
    check("pix_q_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
